multi_pwm: RTL and testbench
============================

Name: multi_pwm

Overview:
- Parametrised N-channel PWM generator; successor to the fixed two-axis, 6-bit pulse generator on the servo/pointer path.
- Adds per-channel duty width, a programmable period, and shadow-buffered duty updates applied only at a period boundary, so no glitched pulses occur.
- Adds registered outputs and a period-boundary strobe.
- Sits between the position sources (Move / RAM storage) and the servo pins.

Parameters:
- CH, 2, number of PWM channels.
- WIDTH, 6, bit width of counter, period and each duty value.

Ports:
- sysclk  in  1  system clock, all logic on rising edge.
- Reset_Sw  in  1  asynchronous active-high reset.
- Enable  in  1  run counter; low = idle.
- Period  in  WIDTH  terminal count P; sampled with Load.
- Duty_In  in  CH*WIDTH  packed duties; channel i at bits [i*WIDTH +: WIDTH].
- Load  in  1  one-cycle strobe that captures Duty_In and Period into the shadow registers.
- Busy  out  1  shadow holds values not yet applied.
- Period_End  out  1  one-cycle strobe on the last count of each period.
- Pulse  out  CH  PWM outputs.

Behaviour:
- Reset (async, Reset_Sw=1):
  - count=0; active and shadow duties=0.
  - Active and shadow period = 2**WIDTH-1.
  - Pulse=0, Busy=0, Period_End=0.
  - Reset mid-period aborts the period immediately; pending shadow data is lost.
- Counter (edge-aligned):
  - Sequence 0,1,...,P_act, then back to 0.
  - Period length is P_act+1 cycles.
  - If P_act=0, count stays 0.
- Pulse[i]:
  - Registered as (count < D_act[i]), so 1-cycle latency from count to pin.
  - D_act=0 gives always low.
  - D_act > P_act gives always high (100%); no wrap or overflow.
- Period_End:
  - Registered; high for one cycle following the cycle where count==P_act, aligned with Pulse.
- Load handshake:
  - Load=1 at an edge: shadow takes Duty_In and Period; Busy goes to 1 the next cycle.
  - Load while Busy=1: shadow is overwritten (last write wins) and Busy stays 1.
- Transfer:
  - At the edge where count==P_act and Enable=1: active takes shadow, Busy clears, and the new values govern count 0 of the next period.
  - Load on the same edge as a transfer: Duty_In/Period go directly to active, shadow is also updated, and Busy stays 0.
- Enable=0:
  - count held at 0; Pulse=0; Period_End=0.
  - Shadow copies to active every cycle, so Load takes effect immediately and Busy never stays set.
- Enable rising: counting starts at 0 on the next edge, using the current active values.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - The counter increments in WIDTH bits; P_act=2**WIDTH-1 wraps naturally.

Optional Feature:
- Macro: MULTI_PWM_CENTER_ALIGN_EN.
- Defined:
  - Adds input Mode (1 bit, sampled into active at transfer like Period).
  - Mode=1 selects up/down counting 0,1,...,P,P-1,...,1, giving a period of 2P cycles.
  - Pulse = count < D, giving 2D-1 high cycles centred on count 0 for 1<=D<=P.
  - Period_End and transfer occur at count==1 while descending.
  - P=0 behaves as edge mode with P=0.
  - Mode=0 is identical to edge-aligned operation.
- Undefined: no Mode port; edge-aligned only.

Test Plan:
- Reset, Enable=1, Load Period=9, Duty_In={ch1=3, ch0=7}: after the first boundary, Pulse[0] is high 7 of 10 cycles, Pulse[1] is high 3 of 10; Period_End every 10 cycles.
- Mid-period (count=4) Load ch0=2: Busy=1 until boundary; current period finishes with 7 high; next period has 2 high; Busy clears at count==9 edge.
- Duty edges with P=9: D=0 gives Pulse constantly 0; D=10 and D=63 give Pulse constantly 1; P=0 with D=1 gives a constant 1 with Period_End every cycle.
- Two Loads (D=5, then D=8) within one period: only 8 applied; Load on the exact count==9 edge applies directly with Busy=0.
- Enable=0 then Load D=4: applied immediately, Pulse=0, count=0; Enable=1 gives 4 high of P+1 from the first period. Reset_Sw pulsed at count=6 clears all outputs within the same cycle.
- With MULTI_PWM_CENTER_ALIGN_EN, Mode=1, P=5, D=3: period of 10 cycles, 5 high cycles centred on count 0; Period_End once per 10 cycles.

Source files
------------

// File: rtl/multi_pwm.sv
// ============================================================================
// Module   : multi_pwm
// Brief    : N-channel edge-aligned PWM with shadow-buffered duty/period
//            updates applied at the period boundary. Optional centre-aligned
//            up/down mode when MULTI_PWM_CENTER_ALIGN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_pwm #(
    parameter int CH    = 2,
    parameter int WIDTH = 6
) (
    input  logic                  sysclk,
    input  logic                  Reset_Sw,
    input  logic                  Enable,
    input  logic [WIDTH-1:0]      Period,
    input  logic [CH*WIDTH-1:0]   Duty_In,
    input  logic                  Load,
`ifdef MULTI_PWM_CENTER_ALIGN_EN
    input  logic                  Mode,
`endif
    output logic                  Busy,
    output logic                  Period_End,
    output logic [CH-1:0]         Pulse
);

    localparam logic [WIDTH-1:0] c_PERIOD_RST = '1;
    localparam logic [WIDTH-1:0] c_ONE        = WIDTH'(1);

    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_period_act;
    logic [WIDTH-1:0]    r_period_sh;
    logic [CH*WIDTH-1:0] r_duty_act;
    logic [CH*WIDTH-1:0] r_duty_sh;
    logic                r_busy;
    logic                r_pend;
    logic [CH-1:0]       r_pulse;

    logic                w_last;
    logic                w_apply;
    logic [WIDTH-1:0]    w_count_nxt;
    logic [CH-1:0]       w_pulse_nxt;

`ifdef MULTI_PWM_CENTER_ALIGN_EN
    logic                r_mode_act;
    logic                r_mode_sh;
    logic                r_down;
    logic                w_center;
    logic                w_down_nxt;

    // P=0 falls back to edge behaviour; P=1 peaks at 1 and ends there.
    always_comb begin
        w_center    = r_mode_act && (r_period_act != '0);
        w_down_nxt  = r_down;
        w_count_nxt = r_count + c_ONE;
        if (w_center) begin
            w_last = (r_count == c_ONE) && (r_down || (r_period_act == c_ONE));
            if (w_last) begin
                w_count_nxt = '0;
                w_down_nxt  = 1'b0;
            end else if (r_down || (r_count == r_period_act)) begin
                w_count_nxt = r_count - c_ONE;
                w_down_nxt  = 1'b1;
            end
        end else begin
            w_last = (r_count == r_period_act);
            if (w_last) begin
                w_count_nxt = '0;
            end
            w_down_nxt = 1'b0;
        end
    end
`else
    always_comb begin
        w_last      = (r_count == r_period_act);
        w_count_nxt = w_last ? '0 : (r_count + c_ONE);
    end
`endif

    // While idle the shadow is transparent, so Busy can never linger.
    assign w_apply = !Enable || w_last;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_pulse
            assign w_pulse_nxt[i] = Enable && (r_count < r_duty_act[i*WIDTH +: WIDTH]);
        end
    endgenerate

    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            r_count      <= '0;
            r_period_act <= c_PERIOD_RST;
            r_period_sh  <= c_PERIOD_RST;
            r_duty_act   <= '0;
            r_duty_sh    <= '0;
            r_busy       <= 1'b0;
            r_pend       <= 1'b0;
            r_pulse      <= '0;
        end else begin
            r_count <= Enable ? w_count_nxt : '0;
            r_pulse <= w_pulse_nxt;
            r_pend  <= Enable && w_last;
            if (Load) begin
                r_period_sh <= Period;
                r_duty_sh   <= Duty_In;
            end
            if (w_apply) begin
                r_period_act <= Load ? Period  : r_period_sh;
                r_duty_act   <= Load ? Duty_In : r_duty_sh;
                r_busy       <= 1'b0;
            end else if (Load) begin
                r_busy <= 1'b1;
            end
        end
    end

`ifdef MULTI_PWM_CENTER_ALIGN_EN
    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            r_mode_act <= 1'b0;
            r_mode_sh  <= 1'b0;
            r_down     <= 1'b0;
        end else begin
            r_down <= Enable ? w_down_nxt : 1'b0;
            if (Load) begin
                r_mode_sh <= Mode;
            end
            if (w_apply) begin
                r_mode_act <= Load ? Mode : r_mode_sh;
            end
        end
    end
`endif

    assign Busy       = r_busy;
    assign Period_End = r_pend;
    assign Pulse      = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_multi_pwm.sv
// ============================================================================
// Module   : tb_multi_pwm
// Brief    : Self-checking bench for multi_pwm (table vectors + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_pwm;

    localparam int CH = 2;
    localparam int W  = 6;

    logic              sysclk = 1'b0;
    logic              Reset_Sw;
    logic              Enable;
    logic [W-1:0]      Period;
    logic [CH*W-1:0]   Duty_In;
    logic              Load;
    logic              Busy;
    logic              Period_End;
    logic [CH-1:0]     Pulse;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
    logic              Mode;
`endif

    multi_pwm #(.CH(CH), .WIDTH(W)) dut (
        .sysclk     (sysclk),
        .Reset_Sw   (Reset_Sw),
        .Enable     (Enable),
        .Period     (Period),
        .Duty_In    (Duty_In),
        .Load       (Load),
`ifdef MULTI_PWM_CENTER_ALIGN_EN
        .Mode       (Mode),
`endif
        .Busy       (Busy),
        .Period_End (Period_End),
        .Pulse      (Pulse)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int p;
        int d0;
        int d1;
        int periods;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl[6];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_duty(input int d0, input int d1);
        Duty_In = {W'(d1), W'(d0)};
    endtask

    task automatic load_idle(input int p, input int d0, input int d1);
        Enable = 1'b0;
        Period = W'(p);
        set_duty(d0, d1);
        Load = 1'b1;
        tick();
        Load = 1'b0;
    endtask

    task automatic run(input int n, output int h0, output int h1,
                       output int pe, output int pe_last);
        h0 = 0; h1 = 0; pe = 0; pe_last = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            h0 += int'(Pulse[0]);
            h1 += int'(Pulse[1]);
            pe += int'(Period_End);
            if (i == n - 1) pe_last = int'(Period_End);
        end
    endtask

    initial begin
        int h0, h1, pe, pl;

        tbl[0] = '{9, 7, 3, 2, 14, 6};
        tbl[1] = '{9, 0, 10, 2, 0, 20};
        tbl[2] = '{9, 63, 63, 2, 20, 20};
        tbl[3] = '{0, 1, 0, 3, 3, 0};
        tbl[4] = '{5, 6, 2, 2, 12, 4};
        tbl[5] = '{63, 1, 62, 1, 1, 62};

        Reset_Sw = 1'b1; Enable = 1'b0; Load = 1'b0; Period = '0; Duty_In = '0;
`ifdef MULTI_PWM_CENTER_ALIGN_EN
        Mode = 1'b0;
`endif
        #12;
        check("rst_pulse", int'(Pulse), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_pend", int'(Period_End), 0);
        @(negedge sysclk);
        Reset_Sw = 1'b0;

        // Reset-default period is 63, so Period_End first appears on edge 64.
        Enable = 1'b1;
        run(64, h0, h1, pe, pl);
        check("rstP_pend_cnt", pe, 1);
        check("rstP_pend_last", pl, 1);
        check("rstP_high0", h0, 0);

        for (int v = 0; v < 6; v++) begin
            load_idle(tbl[v].p, tbl[v].d0, tbl[v].d1);
            check($sformatf("v%0d_idle_busy", v), int'(Busy), 0);
            check($sformatf("v%0d_idle_pulse", v), int'(Pulse), 0);
            check($sformatf("v%0d_idle_pend", v), int'(Period_End), 0);
            Enable = 1'b1;
            run((tbl[v].p + 1) * tbl[v].periods, h0, h1, pe, pl);
            check($sformatf("v%0d_high0", v), h0, tbl[v].e0);
            check($sformatf("v%0d_high1", v), h1, tbl[v].e1);
            check($sformatf("v%0d_pend_cnt", v), pe, tbl[v].periods);
            check($sformatf("v%0d_pend_last", v), pl, 1);
        end

        // Mid-period load at count 4: current period keeps 7, next gets 2.
        load_idle(9, 7, 3);
        Enable = 1'b1;
        h0 = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin Load = 1'b1; set_duty(2, 3); end
            tick();
            Load = 1'b0;
            h0 += int'(Pulse[0]);
            if (k == 5)  check("mid_busy_set", int'(Busy), 1);
            if (k == 9)  check("mid_busy_hold", int'(Busy), 1);
            if (k == 10) check("mid_busy_clr", int'(Busy), 0);
        end
        check("mid_old_high", h0, 7);
        run(10, h0, h1, pe, pl);
        check("mid_new_high", h0, 2);

        // Two loads in one period (last wins), then a load exactly on the boundary.
        load_idle(9, 7, 3);
        Enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) begin Load = 1'b1; set_duty(5, 3); end
            if (k == 6) begin Load = 1'b1; set_duty(8, 3); end
            tick();
            Load = 1'b0;
            if (k == 6)  check("dbl_busy", int'(Busy), 1);
            if (k == 10) check("dbl_busy_clr", int'(Busy), 0);
        end
        h0 = 0;
        for (int k = 11; k <= 20; k++) begin
            if (k == 20) begin Load = 1'b1; set_duty(4, 3); end
            tick();
            Load = 1'b0;
            h0 += int'(Pulse[0]);
        end
        check("dbl_last_wins", h0, 8);
        check("bnd_busy", int'(Busy), 0);
        run(10, h0, h1, pe, pl);
        check("bnd_direct", h0, 4);

        // Asynchronous reset mid-period drops pending shadow data.
        load_idle(9, 7, 3);
        Enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) begin Load = 1'b1; set_duty(2, 3); end
            tick();
            Load = 1'b0;
        end
        check("pre_rst_pulse0", int'(Pulse[0]), 1);
        check("pre_rst_busy", int'(Busy), 1);
        #2;
        Reset_Sw = 1'b1;
        #1;
        check("arst_pulse", int'(Pulse), 0);
        check("arst_busy", int'(Busy), 0);
        check("arst_pend", int'(Period_End), 0);
        #1;
        Reset_Sw = 1'b0;
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        run(64, h0, h1, pe, pl);
        check("arst_shadow_lost", h0, 0);
        check("arst_pend_last", pl, 1);

`ifdef MULTI_PWM_CENTER_ALIGN_EN
        // Up/down P=5 D=3: counts 0..5..1, high on 0,1,2,2,1.
        Mode = 1'b1;
        load_idle(5, 3, 0);
        Enable = 1'b1;
        run(20, h0, h1, pe, pl);
        check("ctr_high0", h0, 10);
        check("ctr_high1", h1, 0);
        check("ctr_pend_cnt", pe, 2);
        check("ctr_pend_last", pl, 1);
        Mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
